// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the shared restoring divider.
package div_pkg;

    localparam int unsigned DEF_NUM_W = 16;
    localparam int unsigned DEF_DEN_W = 8;
    localparam int unsigned CNT_W     = $clog2(DEF_NUM_W);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

endpackage

// File: rtl/div_share_ctrl_if.sv
// Request/response bundle between two requesters and the shared divider.
// Optional macro DIV_ZERO_FLAG_EN adds the dz_o divide-by-zero flag.
interface div_share_ctrl_if #(
    parameter int unsigned NUM_W = 16,
    parameter int unsigned DEN_W = 8
);

    logic [1:0]       req_valid_i;
    logic [1:0]       req_ready_o;
    logic [NUM_W-1:0] num0_i;
    logic [DEN_W-1:0] den0_i;
    logic [NUM_W-1:0] num1_i;
    logic [DEN_W-1:0] den1_i;
    logic [1:0]       rsp_valid_o;
    logic [NUM_W-1:0] quotient_o;
    logic [DEN_W-1:0] remainder_o;
    logic             busy_o;

`ifdef DIV_ZERO_FLAG_EN
    logic             dz_o;

    modport slave (
        input  req_valid_i, num0_i, den0_i, num1_i, den1_i,
        output req_ready_o, rsp_valid_o, quotient_o, remainder_o, busy_o, dz_o
    );

    modport master (
        output req_valid_i, num0_i, den0_i, num1_i, den1_i,
        input  req_ready_o, rsp_valid_o, quotient_o, remainder_o, busy_o, dz_o
    );
`else
    modport slave (
        input  req_valid_i, num0_i, den0_i, num1_i, den1_i,
        output req_ready_o, rsp_valid_o, quotient_o, remainder_o, busy_o
    );

    modport master (
        output req_valid_i, num0_i, den0_i, num1_i, den1_i,
        input  req_ready_o, rsp_valid_o, quotient_o, remainder_o, busy_o
    );
`endif

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a numerator bit, subtract if it fits.
module div_step #(
    parameter int unsigned DEN_W = 8
) (
    input  logic [DEN_W:0] rem_i,
    input  logic           num_bit_i,
    input  logic [DEN_W:0] den_i,
    output logic [DEN_W:0] rem_o,
    output logic           q_bit_o
);

    logic [DEN_W:0] shifted;
    // Partial remainder never exceeds the denominator, so its MSB is dropped on shift.
    logic           unused_rem_msb;

    assign unused_rem_msb = rem_i[DEN_W];
    assign shifted        = {rem_i[DEN_W-1:0], num_bit_i};

    always_comb begin
        q_bit_o = 1'b0;
        rem_o   = shifted;
        if (shifted >= den_i) begin
            q_bit_o = 1'b1;
            rem_o   = shifted - den_i;
        end
    end

endmodule

// File: rtl/div_share_ctrl.sv
// Sequential restoring divider shared by two requesters via round-robin arbitration.
// Optional macro DIV_ZERO_FLAG_EN: zero denominators bypass CALC and raise dz_o.
module div_share_ctrl
    import div_pkg::*;
#(
    parameter int unsigned NUM_W = DEF_NUM_W,
    parameter int unsigned DEN_W = DEF_DEN_W
) (
    input  logic            clk,
    input  logic            rst_n,
    div_share_ctrl_if.slave bus
);

    localparam int unsigned CW = $clog2(NUM_W);

    state_e           state_q;
    logic             last_grant_q;
    logic             owner_q;
    logic [NUM_W-1:0] num_q;
    logic [DEN_W:0]   den_q;
    logic [DEN_W:0]   rem_q;
    logic [CW-1:0]    cnt_q;
    logic [1:0]       rsp_valid_q;
`ifdef DIV_ZERO_FLAG_EN
    logic             dz_q;
`endif

    logic [1:0]       grant;
    logic             owner_nxt;
    logic [NUM_W-1:0] num_sel;
    logic [DEN_W-1:0] den_sel;
    logic [DEN_W:0]   rem_nxt;
    logic             q_bit;

    // Both requesting: the one that did not win last time goes next.
    always_comb begin
        grant = 2'b00;
        if (state_q == IDLE) begin
            case (bus.req_valid_i)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign owner_nxt = grant[1];
    assign num_sel   = owner_nxt ? bus.num1_i : bus.num0_i;
    assign den_sel   = owner_nxt ? bus.den1_i : bus.den0_i;

    div_step #(
        .DEN_W(DEN_W)
    ) u_step (
        .rem_i    (rem_q),
        .num_bit_i(num_q[NUM_W-1]),
        .den_i    (den_q),
        .rem_o    (rem_nxt),
        .q_bit_o  (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            num_q        <= '0;
            den_q        <= '0;
            rem_q        <= '0;
            cnt_q        <= '0;
            rsp_valid_q  <= 2'b00;
`ifdef DIV_ZERO_FLAG_EN
            dz_q         <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant != 2'b00) begin
                        owner_q      <= owner_nxt;
                        last_grant_q <= owner_nxt;
                        den_q        <= {1'b0, den_sel};
                        cnt_q        <= CW'(NUM_W - 1);
`ifdef DIV_ZERO_FLAG_EN
                        if (den_sel == '0) begin
                            state_q     <= DONE;
                            num_q       <= '1;
                            rem_q       <= '1;
                            rsp_valid_q <= grant;
                            dz_q        <= 1'b1;
                        end else begin
                            state_q <= CALC;
                            num_q   <= num_sel;
                            rem_q   <= '0;
                            dz_q    <= 1'b0;
                        end
`else
                        state_q <= CALC;
                        num_q   <= num_sel;
                        rem_q   <= '0;
`endif
                    end
                end
                CALC: begin
                    rem_q <= rem_nxt;
                    num_q <= {num_q[NUM_W-2:0], q_bit};
                    if (cnt_q == '0) begin
                        state_q              <= DONE;
                        rsp_valid_q[owner_q] <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 2'b00;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = grant;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.quotient_o  = num_q;
    assign bus.remainder_o = rem_q[DEN_W-1:0];
    assign bus.busy_o      = (state_q != IDLE);
`ifdef DIV_ZERO_FLAG_EN
    assign bus.dz_o        = dz_q;
`endif

endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
- Sequential restoring divider for 16-bit numerator / 8-bit denominator. Produces one quotient bit per cycle.
- Shared between two requesters through a round-robin arbiter.
- Replaces per-user combinational dividers in multi-client datapaths. Each requester has a valid/ready request channel and a one-cycle response pulse.

Parameters:
- NUM_W, 16, numerator and quotient width
- DEN_W, 8, denominator and remainder width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  2  request valid, bit r belongs to requester r
- req_ready_o  out  2  request accepted when valid&ready at a rising edge
- num0_i  in  NUM_W  requester 0 numerator
- den0_i  in  DEN_W  requester 0 denominator
- num1_i  in  NUM_W  requester 1 numerator
- den1_i  in  DEN_W  requester 1 denominator
- rsp_valid_o  out  2  one-cycle result pulse, bit r for requester r
- quotient_o  out  NUM_W  result quotient, shared by both requesters
- remainder_o  out  DEN_W  result remainder, shared by both requesters
- busy_o  out  1  high whenever state is not IDLE
- dz_o  out  1  divide-by-zero flag; exists only with DIV_ZERO_FLAG_EN

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, last_grant=1 (requester 0 wins first).
  - req_ready_o, rsp_valid_o, busy_o, quotient_o, remainder_o, dz_o all 0.
- States:
  - IDLE -> CALC on an accepted request.
  - CALC -> DONE when the bit counter reaches 0.
  - DONE -> IDLE unconditionally.
- Arbitration, IDLE only:
  - Grant is combinational from req_valid_i and last_grant.
  - Single valid requester: that requester is granted.
  - Both valid: the requester other than last_grant is granted.
  - req_ready_o is one-hot on the granted bit in IDLE, 0 in all other states.
  - On the accept edge, latch owner, numerator and {1'b0,denominator}; set last_grant=owner; clear the 9-bit partial remainder; load cnt=NUM_W-1.
- CALC, each cycle:
  - rem = {rem[7:0], num[MSB]}; num shifts left.
  - If rem >= {1'b0,den}: rem -= den and the new num LSB = 1.
  - Otherwise the new num LSB = 0.
  - cnt decrements; last CALC cycle is cnt==0.
  - Exactly NUM_W CALC cycles.
- Latency:
  - Accept edge at cycle 0, CALC in cycles 1..16, DONE in cycle 17.
  - rsp_valid_o[owner]=1 for exactly cycle 17; the other bit stays 0.
  - quotient_o=num register; remainder_o=rem[7:0].
  - Both are valid from cycle 17 and held until the next accept edge.
  - No response backpressure.
- Back-to-back: the next accept is possible in cycle 18 (first IDLE cycle). Throughput is 1 division per 18 cycles.
- Input changes after the accept edge are ignored; operands are latched.
- Denominator 0 without the macro:
  - Algorithm runs unchanged.
  - quotient_o=16'hFFFF, remainder_o=numerator[7:0].
- Numerator < denominator: quotient 0, remainder = numerator.
- Reset mid-operation:
  - Return to IDLE immediately; no rsp_valid_o pulse.
  - Outputs cleared; in-flight request dropped.

Optional Feature:
- Macro: DIV_ZERO_FLAG_EN.
- Defined:
  - dz_o port exists.
  - Accept with den==0 goes IDLE -> DONE directly, skipping CALC.
  - rsp_valid_o pulses at cycle 1; quotient_o=16'hFFFF, remainder_o=8'hFF.
  - dz_o=1 alongside the pulse and held with the results until the next accept, which clears it.
- Undefined: no dz_o port; zero-denominator behaviour as in Behaviour.

Decomposition:
- Package div_pkg holds:
  - NUM_W/DEN_W default constants
  - state enum {IDLE, CALC, DONE}
  - counter width localparam $clog2(NUM_W)
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: rem 9b, next numerator bit, den 9b.
  - Outputs: new rem 9b, quotient bit.
  - Instantiated once inside the CALC datapath.

Test Plan:
- Req0 only, num=1000, den=7 -> rsp_valid_o=2'b01 at cycle 17; quotient 142, remainder 6; busy_o high in cycles 1..17.
- Req1 only, num=16'hFFFF, den=8'hFF -> rsp_valid_o=2'b10; quotient 16'h0101, remainder 0.
- Both valid in the same cycle after reset:
  - Req0 granted first.
  - Req1 held valid is accepted at cycle 18, its pulse at cycle 35.
  - Then both valid again -> req0 wins (alternation).
- num=5, den=200 -> quotient 0, remainder 5.
- den=0, num=16'h1234:
  - Macro off -> pulse at cycle 17, quotient FFFF, remainder 8'h34.
  - Macro on -> pulse at cycle 1, quotient FFFF, remainder FF, dz_o=1.
- rst_n low at cycle 9 of a division -> all outputs 0 immediately, no pulse; a new request after release completes correctly.
